// File: rtl/clock_display_driver.sv
// Six-digit multiplexed seven-segment driver for the alarm clock core.
// Scans a once-per-frame snapshot of the HH:MM:SS digits onto a
// common-segment display with colon dots. While Alarm is high it blinks
// the whole display and gates the buzzer.
module clock_display_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [2:0] M_out1,
  input  logic [3:0] M_out0,
  input  logic [2:0] S_out1,
  input  logic [3:0] S_out0,
  input  logic       Alarm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       buzz
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  // BCD digit to segments {g,f,e,d,c,b,a}; non-decimal values show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0][3:0]  snap_q, snap_d;
  logic             phase_q, phase_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             buzz_q, buzz_d;

  logic             scan_wrap;
  logic             frame_wrap;
  logic [3:0]       cur_digit;
  logic             visible;

  // Scan counter, digit index and frame snapshot (snapshot only at frame wrap).
  always_comb begin
    scan_wrap  = (div_cnt_q == DIV_LAST);
    frame_wrap = scan_wrap && (idx_q == 3'd5);
    div_cnt_d  = scan_wrap ? '0 : div_cnt_q + DIV_W'(1);
    idx_d      = idx_q;
    if (frame_wrap) begin
      idx_d = 3'd0;
    end else if (scan_wrap) begin
      idx_d = idx_q + 3'd1;
    end
    snap_d = snap_q;
    if (frame_wrap) begin
      snap_d[0] = S_out0;
      snap_d[1] = {1'b0, S_out1};
      snap_d[2] = M_out0;
      snap_d[3] = {1'b0, M_out1};
      snap_d[4] = H_out0;
      snap_d[5] = {2'b00, H_out1};
    end
  end

  // Blink phase: held visible while Alarm is low, toggled every BLINK_DIV frames otherwise.
  always_comb begin
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    if (!Alarm) begin
      phase_d     = 1'b1;
      frame_cnt_d = '0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == FRM_LAST) begin
        phase_d     = ~phase_q;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  // Output decode from the snapshot; a dropped Alarm makes the display visible at once.
  always_comb begin
    case (idx_q)
      3'd0:    cur_digit = snap_q[0];
      3'd1:    cur_digit = snap_q[1];
      3'd2:    cur_digit = snap_q[2];
      3'd3:    cur_digit = snap_q[3];
      3'd4:    cur_digit = snap_q[4];
      default: cur_digit = snap_q[5];
    endcase
    visible = phase_q | ~Alarm;
    an_d    = 6'h3F;
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    if (visible) begin
      an_d = ~(6'b000001 << idx_q);
      if (!((idx_q == 3'd5) && (cur_digit == 4'd0))) begin
        seg_d = seg_decode(cur_digit);
      end
      dp_d = (idx_q == 3'd2) || (idx_q == 3'd4);
    end
    buzz_d = Alarm & phase_q;
  end

  // ---- register stage: scan/blink state and registered display outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      idx_q       <= 3'd0;
      snap_q      <= '0;
      phase_q     <= 1'b1;
      frame_cnt_q <= '0;
      an_q        <= 6'h3F;
      seg_q       <= 7'h00;
      dp_q        <= 1'b0;
      buzz_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      buzz_q      <= buzz_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign buzz = buzz_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver with SCAN_DIV = 4, BLINK_DIV = 2.
// Edges are counted from reset release; a frame is 24 edges, so frame
// wraps happen at edges 24, 48, 72, ...
module tb_clock_display_driver;

  logic       clk;
  logic       reset;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [2:0] M_out1;
  logic [3:0] M_out0;
  logic [2:0] S_out1;
  logic [3:0] S_out0;
  logic       Alarm;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       buzz;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  clock_display_driver #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .reset(reset),
    .H_out1(H_out1), .H_out0(H_out0),
    .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0),
    .Alarm(Alarm),
    .an(an), .seg(seg), .dp(dp), .buzz(buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [2:0] m1, input logic [3:0] m0,
                          input logic [2:0] s1, input logic [3:0] s0);
    H_out1 = h1; H_out0 = h0; M_out1 = m1; M_out0 = m0; S_out1 = s1; S_out0 = s0;
  endtask

  // Call exactly at a frame wrap; checks the whole following visible frame.
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5);
    logic [6:0] es;
    logic [5:0] ea;
    for (int d = 0; d < 6; d++) begin
      case (d)
        0: es = s0;
        1: es = s1;
        2: es = s2;
        3: es = s3;
        4: es = s4;
        default: es = s5;
      endcase
      ea = ~(6'b000001 << d);
      for (int c = 0; c < 4; c++) begin
        tick();
        check_eq({tag, "_an"}, 32'(an), 32'(ea));
        check_eq({tag, "_seg"}, 32'(seg), 32'(es));
        check_eq({tag, "_dp"}, 32'(dp), (d == 2 || d == 4) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    Alarm = 1'b0;
    set_time(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_an", 32'(an), 32'h3F);
    check_eq("rst_seg", 32'(seg), 32'h00);
    check_eq("rst_dp", 32'(dp), 32'd0);
    check_eq("rst_buzz", 32'(buzz), 32'd0);

    // Basic scan of 12:34:56
    set_time(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    tick();
    check_eq("first_an", 32'(an), 32'h3E);
    check_eq("first_seg", 32'(seg), 32'h3F);
    check_eq("first_dp", 32'(dp), 32'd0);
    run_to(24);
    check_frame("scan", 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);

    // Snapshot tearing: 12:34:55 latched at 72, changed while idx = 2
    S_out0 = 4'd5;
    run_to(80);
    S_out0 = 4'd6;
    M_out1 = 3'd5;
    run_to(85);
    check_eq("tear_m1_an", 32'(an), 32'h37);
    check_eq("tear_m1_seg", 32'(seg), 32'h4F);
    run_to(96);
    tick();
    check_eq("tear_s0_an", 32'(an), 32'h3E);
    check_eq("tear_s0_seg", 32'(seg), 32'h7D);
    run_to(109);
    check_eq("tear_m1_new_an", 32'(an), 32'h37);
    check_eq("tear_m1_new_seg", 32'(seg), 32'h6D);
    run_to(120);

    // Leading-zero blanking and invalid digit: 09:5A:00
    set_time(2'd0, 4'd9, 3'd5, 4'd10, 3'd0, 4'd0);
    run_to(144);
    check_frame("lz", 7'h3F, 7'h3F, 7'h40, 7'h6D, 7'h6F, 7'h00);

    // 23:59:59 -> 00:00:00 across a frame boundary
    set_time(2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9);
    run_to(192);
    set_time(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0);
    check_frame("pre_wrap", 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B);
    check_frame("post_wrap", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00);

    // Blink with Alarm high from edge 240
    Alarm = 1'b1;
    tick();
    check_eq("alarm_buzz_on", 32'(buzz), 32'd1);
    check_eq("alarm_an_vis", 32'(an), 32'h3E);
    run_to(288);
    check_eq("last_vis_an", 32'(an), 32'h1F);
    check_eq("last_vis_buzz", 32'(buzz), 32'd1);
    tick();
    check_eq("blank_an", 32'(an), 32'h3F);
    check_eq("blank_seg", 32'(seg), 32'h00);
    check_eq("blank_dp", 32'(dp), 32'd0);
    check_eq("blank_buzz", 32'(buzz), 32'd0);
    run_to(310);
    check_eq("blank_mid_an", 32'(an), 32'h3F);
    check_eq("blank_mid_buzz", 32'(buzz), 32'd0);
    run_to(336);
    check_eq("blank_end_an", 32'(an), 32'h3F);
    tick();
    check_eq("revis_an", 32'(an), 32'h3E);
    check_eq("revis_seg", 32'(seg), 32'h3F);
    check_eq("revis_buzz", 32'(buzz), 32'd1);
    run_to(394);
    check_eq("blank2_an", 32'(an), 32'h3F);
    check_eq("blank2_buzz", 32'(buzz), 32'd0);

    // Drop Alarm during the blank phase
    Alarm = 1'b0;
    tick();
    check_eq("drop_an", 32'(an), 32'h3B);
    check_eq("drop_dp", 32'(dp), 32'd1);
    check_eq("drop_buzz", 32'(buzz), 32'd0);
    tick();
    check_eq("drop_hold_an", 32'(an), 32'h3B);

    // Reset mid-frame at idx = 3 with buzz active
    Alarm = 1'b1;
    tick();
    check_eq("pre_rst_buzz", 32'(buzz), 32'd1);
    check_eq("pre_rst_an", 32'(an), 32'h37);
    reset = 1'b1;
    #2;
    check_eq("async_rst_an", 32'(an), 32'h3F);
    check_eq("async_rst_seg", 32'(seg), 32'h00);
    check_eq("async_rst_dp", 32'(dp), 32'd0);
    check_eq("async_rst_buzz", 32'(buzz), 32'd0);
    Alarm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    tick();
    check_eq("restart_an", 32'(an), 32'h3E);
    check_eq("restart_seg", 32'(seg), 32'h3F);
    run_to(5);
    check_eq("restart_d1_an", 32'(an), 32'h3D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
